// File: rtl/wb_bist_master.sv
// Wishbone classic BIST master: fills a window of the slave with SEED+i,
// reads it back and checks it, or both; reports mismatches and bus timeouts.
module wb_bist_master #(
   parameter int AW  = 3,
   parameter int DW  = 32,
   parameter int TMO = 15
) (
   input  logic          CLK_I,
   input  logic          RST_I,
   input  logic          START,
   input  logic [1:0]    MODE,
   input  logic [AW-1:0] BASE,
   input  logic [AW:0]   LEN,
   input  logic [DW-1:0] SEED,
   output logic          BUSY,
   output logic          DONE,
   output logic [AW:0]   ERR_CNT,
   output logic [AW-1:0] FIRST_ERR_ADR,
   output logic          TMO_ERR,
   output logic          CYC_O,
   output logic          STB_O,
   output logic          WE_O,
   output logic [AW-1:0] ADR_O,
   output logic [DW-1:0] DAT_O,
   input  logic [DW-1:0] DAT_I,
   input  logic          ACK_I,
   output logic [2:0]    DBG_STATE
);

   localparam int TW = $clog2(TMO + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);
   localparam logic [AW:0]   ERR_MAX  = {1'b1, {AW{1'b0}}};

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_WR_REQ = 3'd1,
      S_WR_GAP = 3'd2,
      S_RD_REQ = 3'd3,
      S_RD_GAP = 3'd4,
      S_FINISH = 3'd5
   } state_t;

   state_t        state_q, state_d;
   logic          fc_q, fc_d;
   logic [AW:0]   len_q, len_d;
   logic [AW-1:0] base_q, base_d;
   logic [DW-1:0] seed_q, seed_d;
   logic [AW:0]   idx_q, idx_d;
   logic [AW-1:0] adr_q, adr_d;
   logic [DW-1:0] dat_q, dat_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic [AW:0]   err_cnt_q, err_cnt_d;
   logic [AW-1:0] first_err_q, first_err_d;
   logic          tmo_err_q, tmo_err_d;

   always_ff @(posedge CLK_I) begin
      if (RST_I) begin
         state_q     <= S_IDLE;
         fc_q        <= 1'b0;
         len_q       <= '0;
         base_q      <= '0;
         seed_q      <= '0;
         idx_q       <= '0;
         adr_q       <= '0;
         dat_q       <= '0;
         tmo_q       <= '0;
         err_cnt_q   <= '0;
         first_err_q <= '0;
         tmo_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         fc_q        <= fc_d;
         len_q       <= len_d;
         base_q      <= base_d;
         seed_q      <= seed_d;
         idx_q       <= idx_d;
         adr_q       <= adr_d;
         dat_q       <= dat_d;
         tmo_q       <= tmo_d;
         err_cnt_q   <= err_cnt_d;
         first_err_q <= first_err_d;
         tmo_err_q   <= tmo_err_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      fc_d        = fc_q;
      len_d       = len_q;
      base_d      = base_q;
      seed_d      = seed_q;
      idx_d       = idx_q;
      adr_d       = adr_q;
      dat_d       = dat_q;
      tmo_d       = tmo_q;
      err_cnt_d   = err_cnt_q;
      first_err_d = first_err_q;
      tmo_err_d   = tmo_err_q;
      case (state_q)
         S_IDLE: begin
            if (START) begin
               fc_d        = (MODE == 2'b10);
               len_d       = LEN;
               base_d      = BASE;
               seed_d      = SEED;
               idx_d       = '0;
               adr_d       = BASE;
               dat_d       = SEED;
               tmo_d       = '0;
               err_cnt_d   = '0;
               first_err_d = '0;
               tmo_err_d   = 1'b0;
               if (LEN == '0)   state_d = S_FINISH;
               else if (MODE[0]) state_d = S_RD_REQ;
               else              state_d = S_WR_REQ;
            end
         end
         S_WR_REQ, S_RD_REQ: begin
            if (ACK_I) begin
               // Read data is checked on the same edge that completes the word.
               if (state_q == S_RD_REQ && DAT_I != dat_q) begin
                  if (err_cnt_q == '0) first_err_d = adr_q;
                  if (err_cnt_q != ERR_MAX) err_cnt_d = err_cnt_q + (AW+1)'(1);
               end
               idx_d   = idx_q + (AW+1)'(1);
               adr_d   = adr_q + AW'(1);
               dat_d   = dat_q + DW'(1);
               state_d = (state_q == S_WR_REQ) ? S_WR_GAP : S_RD_GAP;
            end else if (tmo_q == TMO_LAST) begin
               tmo_err_d = 1'b1;
               state_d   = S_FINISH;
            end else begin
               tmo_d = tmo_q + TW'(1);
            end
         end
         S_WR_GAP: begin
            tmo_d = '0;
            if (idx_q != len_q) begin
               state_d = S_WR_REQ;
            end else if (fc_q) begin
               idx_d   = '0;
               adr_d   = base_q;
               dat_d   = seed_q;
               state_d = S_RD_REQ;
            end else begin
               state_d = S_FINISH;
            end
         end
         S_RD_GAP: begin
            tmo_d   = '0;
            state_d = (idx_q != len_q) ? S_RD_REQ : S_FINISH;
         end
         S_FINISH: state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   // The idle gap between strobes keeps the slave's registered read ACK from
   // landing on a following strobe.
   assign CYC_O         = (state_q == S_WR_REQ) || (state_q == S_RD_REQ);
   assign STB_O         = CYC_O;
   assign WE_O          = (state_q == S_WR_REQ);
   assign ADR_O         = adr_q;
   assign DAT_O         = dat_q;
   assign BUSY          = (state_q != S_IDLE) && (state_q != S_FINISH);
   assign DONE          = (state_q == S_FINISH);
   assign ERR_CNT       = err_cnt_q;
   assign FIRST_ERR_ADR = first_err_q;
   assign TMO_ERR       = tmo_err_q;
   assign DBG_STATE     = state_q;

endmodule
